lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous reset, active-high.
REQ-003 in_valid_i  in  1  / in_ready_o  out  1: upstream handshake; the op transfers when both are high.
REQ-004 ren_i  in  1  load request; wen_i  in  1  store request; both low means a non-memory op.
REQ-005 mask_i  in  8  access size: 0x01 byte, 0x03 half, 0x0F word, 0xFF double.
REQ-006 load_zext_i  in  1  1 = zero-extend the load (lbu/lhu/lwu); 0 = sign-extend.
REQ-007 addr_i  in  64  byte address; wdata_i  in  64  store data, LSB-aligned; rd_i  in  5  destination register.
REQ-008 mem_req_valid_o  out  1  / mem_req_ready_i  in  1: memory request handshake.
REQ-009 mem_we_o  out  1;  mem_addr_o  out  64  addr_i with bits[2:0] cleared;  mem_wdata_o  out  64;  mem_wstrb_o  out  8.
REQ-010 mem_resp_valid_i  in  1  single-cycle response pulse;  mem_rdata_i  in  64  aligned doubleword.
REQ-011 out_valid_o  out  1  / out_ready_i  in  1: result handshake toward writeback.
REQ-012 out_rdata_o  out  64;  out_rd_o  out  5;  out_fault_o  out  1  misaligned-access flag.

Function
REQ-013 FSM states: IDLE, REQ, WAIT, DONE. in_ready_o is high only in IDLE.
REQ-014 On accept in IDLE, the LSU registers all inputs. A memory op goes to REQ. A non-memory op goes to DONE with out_rdata_o = 0.
REQ-015 REQ: mem_req_valid_o is held high with stable payload until mem_req_ready_i; on that handshake, go to WAIT. A store goes to WAIT as well; its response carries no data.
REQ-016 WAIT: on mem_resp_valid_i, capture the extracted load result and go to DONE.
REQ-017 DONE: out_valid_o is held high with stable data until out_ready_i; then go to IDLE. No new accept occurs in that same cycle.
REQ-018 Store lane placement: mem_wstrb_o = mask_i << addr[2:0]; mem_wdata_o = wdata_i << (8*addr[2:0]). mem_wstrb_o = 0 for loads.
REQ-019 Load extract: field = mem_rdata_i >> (8*addr[2:0]), truncated to the mask_i size, then sign- or zero-extended to 64 bits per load_zext_i. A double load ignores load_zext_i.
REQ-020 Stores return out_rdata_o = 0.
REQ-021 If ren_i and wen_i are both high, the op is treated as a store.
REQ-022 A mem_resp_valid_i arriving in IDLE, REQ or DONE is ignored.
REQ-023 Latency of a memory op with zero-wait memory: accept at cycle 0, REQ at cycle 1, WAIT at cycle 2, out_valid_o at cycle 3 if the response is in cycle 2.

Reset
REQ-024 rst returns the FSM to IDLE from any state, including mid-REQ and mid-WAIT; the in-flight op is dropped.
REQ-025 Reset values of all outputs are 0, except in_ready_o, which is 1 once in IDLE.

Configuration
REQ-026 With LSU_MISALIGN_CHECK_EN defined, a memory op is checked for natural alignment on accept (half addr[0]=0, word addr[1:0]=0, double addr[2:0]=0). A misaligned op skips REQ/WAIT, goes directly to DONE with out_fault_o=1 and out_rdata_o=0, and issues no memory request.
REQ-027 Without LSU_MISALIGN_CHECK_EN, out_fault_o is tied 0, every op is issued, and strobe/data bits shifted beyond bit 7/63 are discarded.

Structure
REQ-028 The shared defines file holds the mask encodings (byte/half/word/double), the FSM state encoding, and the bus widths for address, data, register index and mask.
REQ-029 One sub-module, lsu_ldext, is combinational: inputs mem_rdata, addr[2:0], mask, zext; output is the 64-bit extended load value.

Verification
REQ-030 lb at addr 0x...03, rdata 0x0000_0000_8000_0000 -> out_rdata_o = 0xFFFF_FFFF_FFFF_FF80 (byte 3 = 0x80); lbu at the same address and data -> 0x80.
REQ-031 sh at addr 0x...06, wdata 0x1234 -> mem_wstrb_o = 0xC0, mem_wdata_o = 0x1234_0000_0000_0000, mem_addr_o = 0x...00.
REQ-032 mem_req_ready_i held low for 4 cycles -> mem_req_valid_o stays high with a constant payload; in_ready_o stays low.
REQ-033 rst asserted in WAIT, followed by a response pulse -> FSM in IDLE, out_valid_o never asserts, response ignored.
REQ-034 lw at addr 0x...02 with the macro defined -> out_fault_o=1 and no mem_req_valid_o. Without the macro -> request issued with wstrb 0 and the load extracted from bytes 2..5.
REQ-035 Non-memory op with out_ready_i low for 3 cycles -> out_valid_o high for 3 cycles with out_rdata_o = 0; accept→IDLE takes 1 cycle after ready.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: bus widths, access-size masks, FSM encoding and alignment helper.
package lsu_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned MASK_W = 8;

  localparam logic [MASK_W-1:0] MASK_BYTE   = 8'h01;
  localparam logic [MASK_W-1:0] MASK_HALF   = 8'h03;
  localparam logic [MASK_W-1:0] MASK_WORD   = 8'h0F;
  localparam logic [MASK_W-1:0] MASK_DOUBLE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Natural-alignment test for an access of the given size at byte offset off.
  function automatic logic is_misaligned(input logic [MASK_W-1:0] mask, input logic [2:0] off);
    logic bad;
    bad = 1'b0;
    case (mask)
      MASK_HALF:   bad = off[0];
      MASK_WORD:   bad = |off[1:0];
      MASK_DOUBLE: bad = |off;
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_ldext.sv
// Combinational load extractor: selects the addressed field of a doubleword and extends it.
module lsu_ldext
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [2:0]        addr,
  input  logic [MASK_W-1:0] mask,
  input  logic              zext,
  output logic [DATA_W-1:0] ldata
);

  logic [DATA_W-1:0] field;

  always_comb begin
    field = mem_rdata >> {addr, 3'b000};
    ldata = field;
    case (mask)
      MASK_BYTE: ldata = zext ? {56'b0, field[7:0]}  : {{56{field[7]}},  field[7:0]};
      MASK_HALF: ldata = zext ? {48'b0, field[15:0]} : {{48{field[15]}}, field[15:0]};
      MASK_WORD: ldata = zext ? {32'b0, field[31:0]} : {{32{field[31]}}, field[31:0]};
      default:   ldata = field;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: accept -> memory request -> response -> writeback.
// Optional natural-alignment fault check enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              ren_i,
  input  logic              wen_i,
  input  logic [MASK_W-1:0] mask_i,
  input  logic              load_zext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_W-1:0]  rd_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [MASK_W-1:0] mem_wstrb_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_rdata_o,
  output logic [REG_W-1:0]  out_rd_o,
  output logic              out_fault_o
);

  state_t            state, state_n;
  logic [2:0]        off_q;
  logic [MASK_W-1:0] mask_q;
  logic              zext_q;
  logic              accept, is_mem, fault;
  logic [DATA_W-1:0] ld_data;

  assign accept = in_valid_i & in_ready_o;
  assign is_mem = ren_i | wen_i;

`ifdef LSU_MISALIGN_CHECK_EN
  assign fault = is_mem & is_misaligned(mask_i, addr_i[2:0]);
`else
  assign fault = 1'b0;
`endif

  lsu_ldext u_ldext (
    .mem_rdata (mem_rdata_i),
    .addr      (off_q),
    .mask      (mask_q),
    .zext      (zext_q),
    .ldata     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept)           state_n = (is_mem && !fault) ? ST_REQ : ST_DONE;
      ST_REQ:  if (mem_req_ready_i)  state_n = ST_WAIT;
      ST_WAIT: if (mem_resp_valid_i) state_n = ST_DONE;
      ST_DONE: if (out_ready_i)      state_n = ST_IDLE;
      default:                       state_n = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state; payload is captured on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_o      <= 1'b1;
      mem_req_valid_o <= 1'b0;
      out_valid_o     <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
      mem_wstrb_o     <= '0;
      out_rdata_o     <= '0;
      out_rd_o        <= '0;
      out_fault_o     <= 1'b0;
      off_q           <= '0;
      mask_q          <= '0;
      zext_q          <= 1'b0;
    end else begin
      in_ready_o      <= (state_n == ST_IDLE);
      mem_req_valid_o <= (state_n == ST_REQ);
      out_valid_o     <= (state_n == ST_DONE);
      if (state == ST_IDLE && accept) begin
        mem_we_o    <= wen_i;
        mem_addr_o  <= {addr_i[ADDR_W-1:3], 3'b000};
        mem_wstrb_o <= wen_i ? MASK_W'(mask_i << addr_i[2:0]) : '0;
        mem_wdata_o <= wen_i ? DATA_W'(wdata_i << {addr_i[2:0], 3'b000}) : '0;
        out_rdata_o <= '0;
        out_rd_o    <= rd_i;
        out_fault_o <= fault;
        off_q       <= addr_i[2:0];
        mask_q      <= mask_i;
        zext_q      <= load_zext_i;
      end
      if (state == ST_WAIT && mem_resp_valid_i && !mem_we_o) out_rdata_o <= ld_data;
    end
  end

endmodule
